// File: rtl/ahb_lite_slave_mem_if.sv
// AHB-Lite bus bundle between a master (or bench) and ahb_lite_slave_mem.
// Hready_in is the bus-level ready; Hready_out/Hresp/Hrdata come from the slave.
interface ahb_lite_slave_mem_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  Hsel;
   logic [ADDR_WIDTH-1:0] Haddr;
   logic [1:0]            Htrans;
   logic                  Hwrite;
   logic [2:0]            Hsize;
   logic [2:0]            Hburst;
   logic [3:0]            Hprot;
   logic [DATA_WIDTH-1:0] Hwdata;
   logic                  Hready_in;
   logic                  Hready_out;
   logic                  Hresp;
   logic [DATA_WIDTH-1:0] Hrdata;

   modport master (
      output Hsel, Haddr, Htrans, Hwrite, Hsize, Hburst, Hprot, Hwdata, Hready_in,
      input  Hready_out, Hresp, Hrdata
   );

   modport slave (
      input  Hsel, Haddr, Htrans, Hwrite, Hsize, Hburst, Hprot, Hwdata, Hready_in,
      output Hready_out, Hresp, Hrdata
   );
endinterface

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite word-organised little-endian RAM slave: pipelined phases, wait states, two-cycle ERROR.
// Define AHB_SLV_RANDOM_WAIT_EN to draw the per-transfer wait count from an 8-bit LFSR.
module ahb_lite_slave_mem #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic                hclk,
   input  logic                hreset,
   ahb_lite_slave_mem_if.slave bus
);
   localparam int NBYTES  = DATA_WIDTH / 8;
   localparam int LANE_AW = $clog2(NBYTES);
   localparam int WORD_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam longint unsigned MEM_BYTES = longint'(MEM_DEPTH) * longint'(NBYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [WORD_AW-1:0]    word_q, word_d;
   logic [NBYTES-1:0]     be_q, be_d;
   logic                  wr_q, wr_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  accept;
   logic                  take;
   logic                  size_err;
   logic                  align_err;
   logic                  range_err;
   logic                  addr_err;
   logic [ADDR_WIDTH-1:0] align_mask;
   logic [WORD_AW-1:0]    a_word;
   logic [NBYTES-1:0]     a_be;
   logic                  commit;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [3:0]            wcnt_load;
   logic                  unused_ok;

   // Byte lanes covered by a transfer of 2**size bytes starting at lane off.
   function automatic logic [NBYTES-1:0] lane_mask(input logic [LANE_AW-1:0] off,
                                                   input logic [2:0]         size);
      logic [NBYTES-1:0] m;
      m = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if ((i >= int'(off)) && (i < (int'(off) + (1 << size)))) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_w,
                                                         input logic [DATA_WIDTH-1:0] new_w,
                                                         input logic [NBYTES-1:0]     be);
      logic [DATA_WIDTH-1:0] w;
      w = old_w;
      for (int i = 0; i < NBYTES; i++) begin
         if (be[i]) w[8*i +: 8] = new_w[8*i +: 8];
      end
      return w;
   endfunction

   // Hburst/Hprot are informational, and Htrans[0] only separates BUSY from IDLE / SEQ from NONSEQ.
   assign unused_ok = ^{bus.Hburst, bus.Hprot, bus.Htrans[0]};

   // Address-phase decode
   always_comb begin
      accept     = bus.Hsel & bus.Hready_in & bus.Htrans[1];
      take       = accept & ((state_q == S_IDLE) | (state_q == S_DATA) | (state_q == S_ERR2));
      size_err   = (bus.Hsize > 3'(LANE_AW));
      align_mask = (ADDR_WIDTH'(1) << bus.Hsize) - ADDR_WIDTH'(1);
      align_err  = |(bus.Haddr & align_mask);
      range_err  = (64'(bus.Haddr) >= MEM_BYTES);
      addr_err   = size_err | align_err | range_err;
      a_word     = bus.Haddr[LANE_AW +: WORD_AW];
      a_be       = lane_mask(bus.Haddr[LANE_AW-1:0], bus.Hsize);
      commit     = (state_q == S_DATA) & wr_q;
      // A write completing on this edge to the same word must be seen by the new read.
      if (commit && (word_q == a_word)) rd_word = merge_lanes(rdata_q, bus.Hwdata, be_q);
      else                              rd_word = mem[a_word];
   end

`ifdef AHB_SLV_RANDOM_WAIT_EN
   logic [7:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (take) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      wcnt_load = {2'b00, lfsr_q[1:0]};
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) lfsr_q <= 8'hA5;
      else        lfsr_q <= lfsr_d;
   end
`else
   assign wcnt_load = 4'(WAIT_STATES);
`endif

   // Next-state and transfer capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      be_d    = be_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      case (state_q)
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_DATA;
         end
         S_ERR1:  state_d = S_ERR2;
         default: state_d = S_IDLE;
      endcase
      if (take) begin
         word_d  = a_word;
         be_d    = a_be;
         wr_d    = bus.Hwrite & ~addr_err;
         rdata_d = rd_word;
         if (addr_err) begin
            state_d = S_ERR1;
         end else if (wcnt_load != 4'd0) begin
            state_d = S_WAIT;
            cnt_d   = wcnt_load;
         end else begin
            state_d = S_DATA;
         end
      end
   end

   always_comb begin
      bus.Hready_out = 1'b1;
      bus.Hresp      = 1'b0;
      bus.Hrdata     = '0;
      case (state_q)
         S_WAIT: bus.Hready_out = 1'b0;
         S_DATA: bus.Hrdata     = rdata_q;
         S_ERR1: begin
            bus.Hready_out = 1'b0;
            bus.Hresp      = 1'b1;
         end
         S_ERR2:  bus.Hresp = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         be_q    <= '0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         be_q    <= be_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage is never reset; a reset drops state_q out of DATA so no pending write lands.
   always_ff @(posedge hclk) begin
      if (commit) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (be_q[i]) mem[word_q][8*i +: 8] <= bus.Hwdata[8*i +: 8];
         end
      end
   end
endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Bench for ahb_lite_slave_mem: two instances (0 and 2 wait states) driven through a shared
// master, checked against a byte-addressed reference memory.
module tb_ahb_lite_slave_mem;
   logic hclk = 1'b0;
   logic hreset;
   always #5 hclk = ~hclk;

   bit          sel;
   logic        m_sel;
   logic [31:0] m_addr;
   logic [1:0]  m_trans;
   logic        m_write;
   logic [2:0]  m_size;
   logic [2:0]  m_burst;
   logic [3:0]  m_prot;
   logic [31:0] m_wdata;
   logic        s_ready;
   logic        s_resp;
   logic [31:0] s_rdata;

   ahb_lite_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
   ahb_lite_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

   assign bus0.Hsel = m_sel & ~sel;
   assign bus1.Hsel = m_sel & sel;
   assign bus0.Haddr = m_addr;    assign bus1.Haddr = m_addr;
   assign bus0.Htrans = m_trans;  assign bus1.Htrans = m_trans;
   assign bus0.Hwrite = m_write;  assign bus1.Hwrite = m_write;
   assign bus0.Hsize = m_size;    assign bus1.Hsize = m_size;
   assign bus0.Hburst = m_burst;  assign bus1.Hburst = m_burst;
   assign bus0.Hprot = m_prot;    assign bus1.Hprot = m_prot;
   assign bus0.Hwdata = m_wdata;  assign bus1.Hwdata = m_wdata;
   assign bus0.Hready_in = bus0.Hready_out;
   assign bus1.Hready_in = bus1.Hready_out;
   assign s_ready = sel ? bus1.Hready_out : bus0.Hready_out;
   assign s_resp  = sel ? bus1.Hresp      : bus0.Hresp;
   assign s_rdata = sel ? bus1.Hrdata     : bus0.Hrdata;

   ahb_lite_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0))
      u_dut0 (.hclk(hclk), .hreset(hreset), .bus(bus0));
   ahb_lite_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2))
      u_dut1 (.hclk(hclk), .hreset(hreset), .bus(bus1));

   int          n_chk = 0;
   int          n_fail = 0;
   logic [7:0]  mdl [int];
   logic [7:0]  lfsr_m [2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int mkey(input logic [31:0] a);
      return (int'(sel) << 20) | int'(a[19:0]);
   endfunction

   task automatic mdl_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
      for (int i = 0; i < (1 << sz); i++) begin
         logic [31:0] ba;
         ba = a + 32'(i);
         mdl[mkey(ba)] = wd[8*int'(ba[1:0]) +: 8];
      end
   endtask

   task automatic mdl_read(input logic [31:0] a, output logic [31:0] w, output bit known);
      logic [31:0] base;
      base  = {a[31:2], 2'b00};
      known = 1'b1;
      w     = '0;
      for (int i = 0; i < 4; i++) begin
         if (mdl.exists(mkey(base + 32'(i)))) w[8*i +: 8] = mdl[mkey(base + 32'(i))];
         else known = 1'b0;
      end
   endtask

   task automatic lfsr_adv();
      lfsr_m[sel] = {lfsr_m[sel][6:0], lfsr_m[sel][7] ^ lfsr_m[sel][5] ^ lfsr_m[sel][4] ^ lfsr_m[sel][3]};
   endtask

   function automatic int exp_lows(input bit err);
      if (err) return 1;
`ifdef AHB_SLV_RANDOM_WAIT_EN
      return int'(lfsr_m[sel][1:0]);
`else
      return sel ? 2 : 0;
`endif
   endfunction

   // One non-pipelined transfer; returns in the cycle after the one ending with Hready_out high.
   task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input bit busy,
                       output logic [31:0] rd, output int lows, output bit fr, output bit fresp,
                       output bit lresp, output bit lowresp);
      @(posedge hclk); #1;
      m_sel = 1'b1; m_trans = 2'b10; m_addr = a; m_write = wr; m_size = sz;
      @(posedge hclk); #1;
      lfsr_adv();
      m_sel = busy; m_trans = busy ? 2'b01 : 2'b00; m_wdata = wd;
      fr = s_ready; fresp = s_resp; lows = 0; lowresp = 1'b0;
      while (s_ready !== 1'b1 && lows < 40) begin
         lowresp |= s_resp;
         lows++;
         @(posedge hclk); #1;
      end
      rd = s_rdata; lresp = s_resp;
   endtask

   task automatic do_xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, input bit busy, output logic [31:0] rd);
      bit err, known, fr, fresp, lresp, lowresp;
      int el, lows;
      logic [31:0] ew;
      err = (sz > 3'd2) || ((a % (32'd1 << sz)) != 0) || (a >= 32'd4096);
      el  = exp_lows(err);
      mdl_read(a, ew, known);
      xfer(wr, a, sz, wd, busy, rd, lows, fr, fresp, lresp, lowresp);
      check("xfer_lows", 64'(lows), 64'(el));
      check("xfer_resp", lresp, err);
      check("xfer_low_resp", lowresp, err);
      if (!err && !wr && known) check("xfer_rdata", rd, ew);
      if (!err && wr) mdl_write(a, sz, wd);
   endtask

   // Word write immediately followed by a read of the same word issued in the write's data cycle.
   task automatic do_pipe(input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
      int el1, el2, n1, n2;
      logic [31:0] ew;
      bit known;
      el1 = exp_lows(1'b0);
      @(posedge hclk); #1;
      m_sel = 1'b1; m_trans = 2'b10; m_addr = a; m_write = 1'b1; m_size = 3'd2;
      @(posedge hclk); #1;
      lfsr_adv();
      el2 = exp_lows(1'b0);
      m_wdata = wd; m_write = 1'b0;
      n1 = 0;
      while (s_ready !== 1'b1 && n1 < 40) begin n1++; @(posedge hclk); #1; end
      @(posedge hclk); #1;
      lfsr_adv();
      m_sel = 1'b0; m_trans = 2'b00;
      n2 = 0;
      while (s_ready !== 1'b1 && n2 < 40) begin n2++; @(posedge hclk); #1; end
      rd = s_rdata;
      mdl_write(a, 3'd2, wd);
      mdl_read(a, ew, known);
      check("pipe_wr_lows", 64'(n1), 64'(el1));
      check("pipe_rd_lows", 64'(n2), 64'(el2));
      check("pipe_resp", s_resp, 1'b0);
      check("pipe_rdata", rd, ew);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   logic [31:0] rd;
   int          lows;
   bit          fr, fresp, lresp, lowresp;

   initial begin
      hreset = 1'b1; sel = 1'b0; m_sel = 1'b0; m_trans = 2'b00; m_addr = '0; m_write = 1'b0;
      m_size = 3'd0; m_burst = 3'd0; m_prot = 4'd0; m_wdata = '0;
      lfsr_m[0] = 8'hA5; lfsr_m[1] = 8'hA5;
      repeat (3) @(posedge hclk);
      #1;
      check("rst_ready0", bus0.Hready_out, 1'b1);
      check("rst_resp0", bus0.Hresp, 1'b0);
      check("rst_rdata0", bus0.Hrdata, 32'h0);
      check("rst_ready1", bus1.Hready_out, 1'b1);
      check("rst_resp1", bus1.Hresp, 1'b0);
      check("rst_rdata1", bus1.Hrdata, 32'h0);
      hreset = 1'b0;

      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         for (int w = 0; w < 64; w++) do_xfer(1'b1, 32'(w * 4), 3'd2, 32'h0, 1'b0, rd);
      end

      // Zero-wait write then read
      sel = 1'b0;
      do_xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0, rd);
      do_xfer(1'b0, 32'h10, 3'd2, 32'h0, 1'b0, rd);
      check("t1_rdata", rd, 32'hDEADBEEF);
      check("t1_ready", s_ready, 1'b1);
      check("t1_resp", s_resp, 1'b0);
      @(posedge hclk); #1;
      check("t1_idle_rdata", s_rdata, 32'h0);

      // Byte-lane write
      do_xfer(1'b1, 32'h10, 3'd2, 32'h11223344, 1'b0, rd);
      do_xfer(1'b1, 32'h13, 3'd0, 32'hAA000000, 1'b0, rd);
      do_xfer(1'b0, 32'h10, 3'd2, 32'h0, 1'b0, rd);
      check("t2_rdata", rd, 32'hAA223344);
      do_xfer(1'b1, 32'h16, 3'd1, 32'hBEEF0000, 1'b0, rd);
      do_xfer(1'b0, 32'h14, 3'd2, 32'h0, 1'b0, rd);
      check("t2_half_rdata", rd, 32'hBEEF0000);

      // Unaligned write takes the two-cycle ERROR and leaves memory alone
      do_xfer(1'b1, 32'h00, 3'd2, 32'h0BADF00D, 1'b0, rd);
      xfer(1'b1, 32'h02, 3'd2, 32'hFFFFFFFF, 1'b0, rd, lows, fr, fresp, lresp, lowresp);
      check("t3_err1_ready", fr, 1'b0);
      check("t3_err1_resp", fresp, 1'b1);
      check("t3_err_lows", 64'(lows), 64'd1);
      check("t3_err2_ready", s_ready, 1'b1);
      check("t3_err2_resp", lresp, 1'b1);
      check("t3_err2_rdata", rd, 32'h0);
      do_xfer(1'b0, 32'h00, 3'd2, 32'h0, 1'b0, rd);
      check("t3_rdata", rd, 32'h0BADF00D);
      do_xfer(1'b0, 32'd4096, 3'd2, 32'h0, 1'b0, rd);
      do_xfer(1'b0, 32'h00, 3'd3, 32'h0, 1'b0, rd);
      do_xfer(1'b1, 32'hFFC, 3'd2, 32'h600DCAFE, 1'b0, rd);
      do_xfer(1'b0, 32'hFFC, 3'd2, 32'h0, 1'b0, rd);
      check("t3_lastword", rd, 32'h600DCAFE);

      // Two wait states
      sel = 1'b1;
      do_xfer(1'b1, 32'h20, 3'd2, 32'hCAFEF00D, 1'b0, rd);
      xfer(1'b0, 32'h20, 3'd2, 32'h0, 1'b0, rd, lows, fr, fresp, lresp, lowresp);
`ifndef AHB_SLV_RANDOM_WAIT_EN
      check("t4_lows", 64'(lows), 64'd2);
`endif
      check("t4_wait_resp", lowresp, 1'b0);
      check("t4_ready", s_ready, 1'b1);
      check("t4_rdata", rd, 32'hCAFEF00D);

      // Read-after-write forwarding
      sel = 1'b0;
      do_pipe(32'h40, 32'h00000005, rd);
      check("t5_rdata", rd, 32'h00000005);
      sel = 1'b1;
      do_pipe(32'h44, 32'h00000007, rd);
      check("t5_wait_rdata", rd, 32'h00000007);

      // Reset in the middle of a write's wait
      do_xfer(1'b1, 32'h30, 3'd2, 32'h0, 1'b0, rd);
      @(posedge hclk); #1;
      m_sel = 1'b1; m_trans = 2'b10; m_addr = 32'h30; m_write = 1'b1; m_size = 3'd2;
      @(posedge hclk); #1;
      m_sel = 1'b0; m_trans = 2'b00; m_wdata = 32'h12345678;
`ifndef AHB_SLV_RANDOM_WAIT_EN
      check("t6_in_wait", s_ready, 1'b0);
`endif
      #2 hreset = 1'b1;
      #1;
      check("t6_rst_ready", s_ready, 1'b1);
      check("t6_rst_resp", s_resp, 1'b0);
      check("t6_rst_rdata", s_rdata, 32'h0);
      lfsr_m[0] = 8'hA5; lfsr_m[1] = 8'hA5;
      repeat (2) @(posedge hclk);
      #1 hreset = 1'b0;
      do_xfer(1'b0, 32'h30, 3'd2, 32'h0, 1'b0, rd);
      check("t6_rdata", rd, 32'h0);

      // Randomised traffic against the reference memory
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         for (int i = 0; i < 70; i++) begin
            int          r;
            logic [2:0]  sz;
            logic [31:0] a;
            r  = int'($urandom_range(0, 9));
            sz = 3'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 255));
            if (r == 0) begin
               do_pipe({a[31:2], 2'b00}, $urandom, rd);
            end else begin
               if (r == 1) a = 32'd4096 + 32'($urandom_range(0, 64));
               if (r >= 5) a = a & ~((32'd1 << sz) - 32'd1);
               do_xfer(1'($urandom_range(0, 1)), a, sz, $urandom, 1'($urandom_range(0, 1)), rd);
            end
         end
      end

      @(posedge hclk); #1;
      m_sel = 1'b0; m_trans = 2'b00;
      repeat (2) @(posedge hclk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
